seq_ram_fetcher: RTL and testbench
==================================

# seq_ram_fetcher

Multi-channel, parametrised sequence fetcher between the sequence RAM and the main controller's command engines. Each channel requests a sequence by ID, pulsed. The block round-robin arbitrates the pending requests and either:
- bursts `SEQ_WORDS` words out of the sequence RAM, which has a configurable read latency, or
- substitutes a strap-selected default sequence.

It presents a per-channel, level-valid, multi-word sequence image to the consumers.

## Interface
- `NUM_CH`, 2: number of requesting channels (1..8).
- `SEQ_WORDS`, 4: words per sequence (1..8).
- `DATA_W`, 32: sequence RAM data width.
- `ADDR_W`, 10: sequence RAM address width.
- `ADDR_STRIDE`, 4: address increment between consecutive words of one sequence.
- `RAM_LAT`, 1: cycles from `seq_ram_rd_en` to valid `seq_ram_rd_data` (1..3).

Ports:
- `mem_clk`  in  1  block clock; one clock only.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `seq_sel`  in  `NUM_CH`  per-channel request pulse.
- `seq_id`  in  `NUM_CH*(ADDR_W+1)`  packed IDs; channel c at `[c*(ADDR_W+1) +: ADDR_W+1]`; MSB=1 selects default sequence, low `ADDR_W` bits are the RAM base address.
- `def_seq_sel`  in  1  strap; selects default set 0 or 1.
- `def_seq`  in  `2*SEQ_WORDS*DATA_W`  default sets; set s word w at `[(s*SEQ_WORDS+w)*DATA_W +: DATA_W]`.
- `seq_ram_rd_addr`  out  `ADDR_W`  registered RAM read address.
- `seq_ram_rd_en`  out  1  registered RAM read strobe, one cycle per word.
- `seq_ram_rd_data`  in  `DATA_W`  RAM read data.
- `seq_valid`  out  `NUM_CH`  per-channel level valid.
- `seq_data`  out  `NUM_CH*SEQ_WORDS*DATA_W`  channel c word w at `[(c*SEQ_WORDS+w)*DATA_W +: DATA_W]`.
- `busy`  out  1  high while state is not IDLE.

## Operation
- Reset values: `seq_ram_rd_addr`=0, `seq_ram_rd_en`=0, `seq_valid`=0, `seq_data`=0, `busy`=0.
- Reset also clears all pending/re-request bits, the round-robin pointer (channel 0 has first priority), `init_done`, and all counters.
- **Reset mid-fetch** aborts the fetch with no partial valid.
- **Init:** in the first cycle after reset release (`init_done`=0), every channel whose `seq_id` MSB=1 loads default set `def_seq_sel` and sets `seq_valid`. `init_done` is then set and never re-runs until the next reset.
- **Request:** `seq_sel[c]` high clears `seq_valid[c]` and sets `pending[c]` at the next edge. Pulses on several channels in the same cycle are all latched.
- **States:** IDLE, FETCH, DRAIN.
- **IDLE:** grants the first pending channel found searching upward, with wrap-around, starting from the channel after the last granted one. On grant, `seq_id` is sampled.
  - MSB=1: load the default set into that channel's words, set `seq_valid`, clear `pending`, stay in IDLE.
  - MSB=0: register `seq_ram_rd_addr`=base and `seq_ram_rd_en`=1, then go to FETCH.
- **FETCH:** issues one read per cycle; word k address = base + k*`ADDR_STRIDE`, modulo 2^`ADDR_W` (wraps silently). After issuing word `SEQ_WORDS`-1, go to DRAIN.
- **Capture:** data is captured into word k of the granted channel `RAM_LAT` cycles after word k's `seq_ram_rd_en`, tracked by a `RAM_LAT`-deep delayed-strobe pipe and a capture counter.
- **DRAIN:** waits until `SEQ_WORDS` words are captured, then sets `seq_valid`, clears `pending`, and returns to IDLE. The capture of the last word and the valid set happen on the same edge.
- **Same-channel re-request:** `seq_sel` of the active channel during FETCH/DRAIN sets its re-request bit. At completion the data is still written, but `seq_valid` stays 0 and `pending` stays set. The channel is re-fetched later with the then-current `seq_id`.
- **Other-channel requests** during a fetch only set `pending`; they have no effect on the current fetch.
- **Address hold:** `seq_ram_rd_addr` holds its last value when no read is issued.
- **Words not written:** words of channels not being fetched are never modified.

## Timing
- Request `seq_sel` in cycle 0 (RAM path):
  - `pending` is high in cycle 1.
  - word k `seq_ram_rd_en` is in cycle 2+k.
  - `seq_valid` rises in cycle `SEQ_WORDS`+`RAM_LAT`+2 (7 with default parameters).
- Default path: `seq_valid` rises in cycle 2.
- Back-to-back RAM fetches for different channels: the next `seq_ram_rd_en` burst starts `SEQ_WORDS`+`RAM_LAT`+1 cycles after the previous burst's first strobe.
- `seq_valid[c]` falls in the cycle after `seq_sel[c]`, even if a fetch for c is in progress.

## Test plan
- Reset with channel 0 ID=0x400 and channel 1 ID=0x010, `def_seq_sel`=1 -> channel 0: `seq_valid`=1 in cycle 1 after release, holding set-1 words. Channel 1: valid=0, data 0.
- Channel 1 `seq_sel` with ID=0x010, RAM returns 0xA0..0xA3 at 0x10/0x14/0x18/0x1C, `RAM_LAT`=1 -> strobes in cycles 2..5 at those addresses; `seq_valid[1]` rises in cycle 7 with words 0xA0..0xA3.
- `seq_sel` on both channels in the same cycle, both ID=0x020, pointer after last grant to channel 1 -> channel 0 fetched first, channel 1 burst starts 6 cycles later; both valid with correct data.
- ID=0x3FC with `ADDR_STRIDE`=4 -> addresses 0x3FC, 0x000, 0x004, 0x008.
- `seq_sel[0]` repeated during channel 0's FETCH with a new ID 0x040 -> no valid at the first completion; second burst at 0x040; valid after the second burst.
- Rebuild with `RAM_LAT`=3, `SEQ_WORDS`=8 -> valid in cycle 13; `reset_n_i` low mid-burst -> all outputs 0 asynchronously, no stale valid after release.

Source files
------------

// File: rtl/seq_ram_fetcher.sv
// Round-robin sequence fetcher: bursts SEQ_WORDS words from the sequence RAM (or a strapped
// default set) into a per-channel, level-valid sequence image.
module seq_ram_fetcher #(
    parameter int NUM_CH      = 2,
    parameter int SEQ_WORDS   = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int ADDR_STRIDE = 4,
    parameter int RAM_LAT     = 1
) (
    input  logic                               mem_clk,
    input  logic                               reset_n_i,
    input  logic [NUM_CH-1:0]                  seq_sel,
    input  logic [NUM_CH*(ADDR_W+1)-1:0]       seq_id,
    input  logic                               def_seq_sel,
    input  logic [2*SEQ_WORDS*DATA_W-1:0]      def_seq,
    output logic [ADDR_W-1:0]                  seq_ram_rd_addr,
    output logic                               seq_ram_rd_en,
    input  logic [DATA_W-1:0]                  seq_ram_rd_data,
    output logic [NUM_CH-1:0]                  seq_valid,
    output logic [NUM_CH*SEQ_WORDS*DATA_W-1:0] seq_data,
    output logic                               busy
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W = (SEQ_WORDS > 1) ? $clog2(SEQ_WORDS) : 1;

    // state  | meaning
    // IDLE   | arbitrate pending channels, serve default-ID grants in place
    // FETCH  | issue one RAM read per cycle for the granted channel
    // DRAIN  | wait for the remaining read data, then publish
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

    state_t              r_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_valid;
    logic                r_rereq;
    logic                r_init_done;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_gnt;
    logic [WD_W-1:0]     r_issue;
    logic [WD_W-1:0]     r_cap_cnt;
    logic [RAM_LAT-1:0]  r_pipe;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_en;
    logic [DATA_W-1:0]   r_data [NUM_CH][SEQ_WORDS];

    logic [ADDR_W:0]     w_id [NUM_CH];
    logic [DATA_W-1:0]   w_def [SEQ_WORDS];
    logic [NUM_CH-1:0]   w_pend_rot;
    logic                w_found;
    logic [CH_W:0]       w_sum;
    logic [CH_W-1:0]     w_gnt_idx;
    logic [CH_W-1:0]     w_next_ptr;
    logic [ADDR_W:0]     w_gnt_id;
    logic                w_cap;
    logic                w_last_cap;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_id
        assign w_id[c] = seq_id[c*(ADDR_W+1) +: ADDR_W+1];
    end

    for (genvar w = 0; w < SEQ_WORDS; w++) begin : g_def
        assign w_def[w] = def_seq_sel ? def_seq[(SEQ_WORDS+w)*DATA_W +: DATA_W]
                                      : def_seq[w*DATA_W +: DATA_W];
    end

    // Pending bits rotated so bit 0 is the channel after the last grant.
    assign w_pend_rot = NUM_CH'({r_pending, r_pending} >> r_rr_ptr);

    always_comb begin
        w_found   = 1'b0;
        w_sum     = '0;
        w_gnt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pend_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
                if (w_sum >= (CH_W+1)'(NUM_CH)) begin
                    w_sum = w_sum - (CH_W+1)'(NUM_CH);
                end
                w_gnt_idx = w_sum[CH_W-1:0];
            end
        end
    end

    assign w_next_ptr = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_id   = w_id[w_gnt_idx];
    assign w_cap      = r_pipe[RAM_LAT-1];
    assign w_last_cap = w_cap && (r_cap_cnt == WD_W'(SEQ_WORDS - 1));

    always_ff @(posedge mem_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_valid     <= '0;
            r_rereq     <= 1'b0;
            r_init_done <= 1'b0;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_issue     <= '0;
            r_cap_cnt   <= '0;
            r_pipe      <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int w = 0; w < SEQ_WORDS; w++) begin
                    r_data[c][w] <= '0;
                end
            end
        end else begin
            r_pipe <= (r_pipe << 1) | RAM_LAT'(r_rd_en);

            if (!r_init_done) begin
                r_init_done <= 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_id[c][ADDR_W]) begin
                        r_valid[c] <= 1'b1;
                        for (int w = 0; w < SEQ_WORDS; w++) begin
                            r_data[c][w] <= w_def[w];
                        end
                    end
                end
            end

            if (w_cap) begin
                r_data[r_gnt][r_cap_cnt] <= seq_ram_rd_data;
                r_cap_cnt                <= r_cap_cnt + 1'b1;
            end

            if (r_state != ST_IDLE && seq_sel[r_gnt]) begin
                r_rereq <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_rr_ptr <= w_next_ptr;
                        if (w_gnt_id[ADDR_W]) begin
                            r_valid[w_gnt_idx]   <= 1'b1;
                            r_pending[w_gnt_idx] <= 1'b0;
                            for (int w = 0; w < SEQ_WORDS; w++) begin
                                r_data[w_gnt_idx][w] <= w_def[w];
                            end
                        end else begin
                            r_gnt     <= w_gnt_idx;
                            r_rd_addr <= w_gnt_id[ADDR_W-1:0];
                            r_rd_en   <= 1'b1;
                            r_issue   <= '0;
                            r_cap_cnt <= '0;
                            r_rereq   <= 1'b0;
                            r_state   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (r_issue == WD_W'(SEQ_WORDS - 1)) begin
                        r_rd_en <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_issue   <= r_issue + 1'b1;
                        r_rd_addr <= r_rd_addr + ADDR_W'(ADDR_STRIDE);
                        r_rd_en   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_cap) begin
                        if (!r_rereq) begin
                            r_valid[r_gnt]   <= 1'b1;
                            r_pending[r_gnt] <= 1'b0;
                        end
                        r_rereq <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // New requests override any same-edge publish so valid always drops after seq_sel.
            for (int c = 0; c < NUM_CH; c++) begin
                if (seq_sel[c]) begin
                    r_valid[c]   <= 1'b0;
                    r_pending[c] <= 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar w = 0; w < SEQ_WORDS; w++) begin : g_wd
            assign seq_data[(c*SEQ_WORDS+w)*DATA_W +: DATA_W] = r_data[c][w];
        end
    end

    assign seq_ram_rd_addr = r_rd_addr;
    assign seq_ram_rd_en   = r_rd_en;
    assign seq_valid       = r_valid;
    assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seq_ram_fetcher.sv
// Bench for seq_ram_fetcher: default build (LAT 1, 4 words) plus a LAT 3 / 8 word build,
// each fed by a behavioural RAM; a per-cycle checker compares published images to the model.
module tb_seq_ram_fetcher;
    localparam int NC  = 2;
    localparam int SW  = 4;
    localparam int SWB = 8;
    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int STR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_a, rst_b, dsel;
    logic [NC-1:0]          sel_a, sel_b, val_a, val_b;
    logic [NC*(AW+1)-1:0]   id_a, id_b;
    logic [2*SW*DW-1:0]     def_a;
    logic [2*SWB*DW-1:0]    def_b;
    logic [AW-1:0]          addr_a, addr_b;
    logic                   en_a, en_b, busy_a, busy_b;
    logic [DW-1:0]          rdata_a, rdata_b;
    logic [NC*SW*DW-1:0]    data_a;
    logic [NC*SWB*DW-1:0]   data_b;

    seq_ram_fetcher #(.NUM_CH(NC), .SEQ_WORDS(SW), .DATA_W(DW), .ADDR_W(AW),
                      .ADDR_STRIDE(STR), .RAM_LAT(1)) u_dut_a (
        .mem_clk(clk), .reset_n_i(rst_a), .seq_sel(sel_a), .seq_id(id_a),
        .def_seq_sel(dsel), .def_seq(def_a), .seq_ram_rd_addr(addr_a),
        .seq_ram_rd_en(en_a), .seq_ram_rd_data(rdata_a), .seq_valid(val_a),
        .seq_data(data_a), .busy(busy_a));

    seq_ram_fetcher #(.NUM_CH(NC), .SEQ_WORDS(SWB), .DATA_W(DW), .ADDR_W(AW),
                      .ADDR_STRIDE(STR), .RAM_LAT(3)) u_dut_b (
        .mem_clk(clk), .reset_n_i(rst_b), .seq_sel(sel_b), .seq_id(id_b),
        .def_seq_sel(dsel), .def_seq(def_b), .seq_ram_rd_addr(addr_b),
        .seq_ram_rd_en(en_b), .seq_ram_rd_data(rdata_b), .seq_valid(val_b),
        .seq_data(data_b), .busy(busy_b));

    // Behavioural RAM: data for the address presented in cycle t appears in cycle t+LAT.
    logic [DW-1:0] mem [0:1023];
    logic [AW-1:0] ra_q;
    logic [AW-1:0] rb_q [3];
    always @(posedge clk) begin
        ra_q    <= addr_a;
        rb_q[0] <= addr_b;
        rb_q[1] <= rb_q[0];
        rb_q[2] <= rb_q[1];
    end
    assign rdata_a = mem[ra_q];
    assign rdata_b = mem[rb_q[2]];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;
    int log_c[$];
    int log_a[$];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] defw(input logic s, input int w);
        return 32'hD000_0000 | (32'(s) << 24) | 32'(w);
    endfunction

    // Expected image word w for a request ID under the current strap.
    function automatic logic [DW-1:0] img(input logic [AW:0] id, input int w);
        logic [AW-1:0] a;
        if (id[AW]) return defw(dsel, w);
        a = id[AW-1:0] + AW'(STR * w);
        return mem[a];
    endfunction

    logic [AW:0]   m_id [NC];
    logic [NC-1:0] prev_sel;
    always @(negedge clk) begin
        if (!rst_a) begin
            for (int c = 0; c < NC; c++) m_id[c] = id_a[c*(AW+1) +: AW+1];
            prev_sel = '0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (prev_sel[c]) chk($sformatf("valid_fall_ch%0d", c), val_a[c], 1'b0);
                if (val_a[c]) begin
                    for (int w = 0; w < SW; w++)
                        chk($sformatf("image_ch%0d_w%0d", c, w),
                            data_a[(c*SW+w)*DW +: DW], img(m_id[c], w));
                end
                if (sel_a[c]) m_id[c] = id_a[c*(AW+1) +: AW+1];
            end
            if (en_a) chk("busy_during_read", busy_a, 1'b1);
            prev_sel = sel_a;
        end
        if (en_a) begin
            log_c.push_back(cyc - t0);
            log_a.push_back(int'(addr_a));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [NC-1:0] m);
        t0 = cyc;
        log_c.delete();
        log_a.delete();
        sel_a = m;
        step();
        sel_a = '0;
    endtask

    task automatic wait_val_a(input int ch, input int limit, output int rise);
        while (!val_a[ch] && (cyc - t0) < limit) step();
        rise = val_a[ch] ? (cyc - t0) : -1;
    endtask

    int r;
    int seen;
    int exp4[4];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 | 32'(i);
        mem[10'h10] = 32'hA0; mem[10'h14] = 32'hA1;
        mem[10'h18] = 32'hA2; mem[10'h1C] = 32'hA3;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < SW; w++)  def_a[(s*SW+w)*DW +: DW]  = defw(s[0], w);
            for (int w = 0; w < SWB; w++) def_b[(s*SWB+w)*DW +: DW] = defw(s[0], w);
        end
        rst_a = 1'b0; rst_b = 1'b0; sel_a = '0; sel_b = '0; dsel = 1'b1;
        id_a = {11'h010, 11'h400};
        id_b = {11'h000, 11'h100};
        repeat (3) step();

        chk("rst_addr", addr_a, 0);
        chk("rst_en", en_a, 0);
        chk("rst_valid", val_a, 0);
        chk("rst_data", |data_a, 0);
        chk("rst_busy", busy_a, 0);

        rst_a = 1'b1; rst_b = 1'b1;
        step();
        chk("init_valid", val_a, 2'b01);
        chk("init_ch0_w0", data_a[0 +: DW], 32'hD100_0000);
        chk("init_ch0_w3", data_a[3*DW +: DW], 32'hD100_0003);
        chk("init_ch1_data", |data_a[SW*DW +: SW*DW], 0);
        chk("init_b_valid", val_b, 0);
        step(); step();

        // Single RAM fetch on channel 1.
        pulse_a(2'b10);
        wait_val_a(1, 30, r);
        chk("t2_valid_cycle", r, 7);
        chk("t2_strobes", log_c.size(), 4);
        for (int k = 0; k < 4 && k < log_c.size(); k++) begin
            chk($sformatf("t2_stb%0d_cycle", k), log_c[k], 2 + k);
            chk($sformatf("t2_stb%0d_addr", k), log_a[k], 32'h10 + 4 * k);
        end
        chk("t2_w0", data_a[(SW+0)*DW +: DW], 32'hA0);
        chk("t2_w3", data_a[(SW+3)*DW +: DW], 32'hA3);
        step(); step();

        // Simultaneous requests; pointer sits on channel 0 after granting channel 1.
        id_a = {11'h020, 11'h020};
        pulse_a(2'b11);
        wait_val_a(0, 30, r);
        chk("t3_ch0_valid_cycle", r, 7);
        wait_val_a(1, 40, r);
        chk("t3_ch1_valid_cycle", r, 13);
        chk("t3_strobes", log_c.size(), 8);
        if (log_c.size() == 8) begin
            chk("t3_burst2_start", log_c[4], 8);
            chk("t3_burst2_addr0", log_a[4], 32'h20);
            chk("t3_burst2_addr3", log_a[7], 32'h2C);
        end
        step(); step();

        // Address wrap at the top of the RAM.
        id_a[10:0] = 11'h3FC;
        exp4 = '{32'h3FC, 32'h000, 32'h004, 32'h008};
        pulse_a(2'b01);
        wait_val_a(0, 30, r);
        chk("t4_valid_cycle", r, 7);
        chk("t4_strobes", log_a.size(), 4);
        for (int k = 0; k < 4 && k < log_a.size(); k++)
            chk($sformatf("t4_addr%0d", k), log_a[k], exp4[k]);
        step(); step();

        // Same-channel re-request during FETCH with a new ID.
        id_a[10:0] = 11'h030;
        pulse_a(2'b01);
        step(); step();
        id_a[10:0] = 11'h040;
        sel_a = 2'b01;
        step();
        sel_a = '0;
        while ((cyc - t0) < 7) step();
        chk("t5_no_first_valid", val_a[0], 0);
        wait_val_a(0, 40, r);
        chk("t5_valid_cycle", r, 13);
        chk("t5_strobes", log_a.size(), 8);
        if (log_a.size() == 8) begin
            chk("t5_first_addr", log_a[0], 32'h30);
            chk("t5_second_start", log_c[4], 8);
            chk("t5_second_addr", log_a[4], 32'h40);
        end
        step(); step();

        // Default path with strap set 0.
        dsel = 1'b0;
        id_a[21:11] = 11'h405;
        pulse_a(2'b10);
        wait_val_a(1, 20, r);
        chk("t6_valid_cycle", r, 2);
        chk("t6_w0", data_a[(SW+0)*DW +: DW], 32'hD000_0000);
        chk("t6_w2", data_a[(SW+2)*DW +: DW], 32'hD000_0002);
        chk("t6_ch0_kept", val_a[0], 1'b1);

        // LAT 3 / 8-word build.
        t0 = cyc;
        sel_b = 2'b01;
        step();
        sel_b = '0;
        while (!val_b[0] && (cyc - t0) < 40) step();
        r = val_b[0] ? (cyc - t0) : -1;
        chk("b_valid_cycle", r, 13);
        for (int w = 0; w < SWB; w++)
            chk($sformatf("b_w%0d", w), data_b[w*DW +: DW], img(11'h100, w));

        // Reset in the middle of a burst.
        t0 = cyc;
        sel_b = 2'b01;
        step();
        sel_b = '0;
        while ((cyc - t0) < 4) step();
        chk("b_mid_burst_en", en_b, 1'b1);
        rst_b = 1'b0;
        #1;
        chk("b_rst_en", en_b, 0);
        chk("b_rst_addr", addr_b, 0);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_valid", val_b, 0);
        chk("b_rst_data", |data_b, 0);
        step(); step();
        rst_b = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            if (val_b != 0 || en_b) seen = 1;
        end
        chk("b_no_stale_after_reset", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
